// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_seq_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int DEFAULT_DIGITS = 8;
    localparam int DEFAULT_BIN_W  = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between a client and the converter
interface bin2bcd_seq_if
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = DEFAULT_BIN_W,
    parameter int DIGITS = DEFAULT_DIGITS
);

    logic                            start;
    logic [BIN_W-1:0]                bin;
    logic                            busy;
    logic                            done;
    logic [BCD_DIGIT_W*DIGITS-1:0]   bcd;
    logic                            ovf;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ovf
    );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// rtl/bin2bcd_seq_add3.sv - per-digit add-3 correction applied before each shift
module bin2bcd_seq_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] in_digit,
    output logic [BCD_DIGIT_W-1:0] out_digit
);

    // A digit of 5 or more would become >= 10 after doubling, so pre-bias it by 3.
    always_comb begin
        out_digit = in_digit;
        if (in_digit >= BCD_DIGIT_W'(5)) begin
            out_digit = in_digit + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - double-dabble converter, one add-3/shift step per clock
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = DEFAULT_BIN_W,
    parameter int DIGITS = DEFAULT_DIGITS
)(
    input  logic          CLOCK_50,
    input  logic          RESET,
    bin2bcd_seq_if.slave  bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   bin_sh_q;
    logic [BCD_W-1:0]   work_q;
    logic               ovf_work_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;

    logic [BCD_W-1:0]   corr;
    logic [BCD_W-1:0]   work_next;
    logic               out_bit;
    logic               accept;
    logic               last_step;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bin2bcd_seq_add3 u_add3 (
                .in_digit  (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .out_digit (corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The corrected digits shift left one place, taking the next binary MSB in at the bottom;
    // the bit leaving the top digit means the value does not fit in DIGITS digits.
    always_comb begin
        work_next = {corr[BCD_W-2:0], bin_sh_q[BIN_W-1]};
        out_bit   = corr[BCD_W-1];
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status outputs; start is only honoured when not shifting.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus.busy = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    last_step = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Working registers, iteration counter and the result registers that only move on the last step.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            cnt_q      <= '0;
            bin_sh_q   <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else if (accept) begin
            cnt_q      <= CNT_W'(BIN_W);
            bin_sh_q   <= bus.bin;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
        end else if (state_q == ST_SHIFT) begin
            cnt_q      <= cnt_q - CNT_W'(1);
            bin_sh_q   <= bin_sh_q << 1;
            work_q     <= work_next;
            ovf_work_q <= ovf_work_q | out_bit;
            if (last_step) begin
                bcd_q <= work_next;
                ovf_q <= ovf_work_q | out_bit;
            end
        end
    end

    assign bus.bcd = bcd_q;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t        vecs [10];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_bcd = '0;
    logic        prev_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by repeated division; overflow when the value needs a 9th digit.
    function automatic void model(input int unsigned v, output logic [31:0] b, output logic o);
        int unsigned t;
        t = v;
        b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            b[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        o = (v > 99999999);
    endfunction

    // Called at a negedge: request conversion, return at the negedge of cycle t+1.
    task automatic start_conv(input logic [26:0] v);
        bus.start = 1'b1;
        bus.bin   = v;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        bus.bin   = 27'($urandom);
    endtask

    // Follow the conversion until done, optionally injecting a start at cycle t+inject_at.
    task automatic wait_done(input int inject_at, input logic [26:0] inject_bin,
                             output int lat, output int busy_cnt, output int hold_bad);
        lat = 1;
        busy_cnt = 0;
        hold_bad = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            if (bus.bcd !== prev_bcd || bus.ovf !== prev_ovf) hold_bad++;
            if (lat == inject_at) begin
                bus.start = 1'b1;
                bus.bin   = inject_bin;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge CLOCK_50);
            lat++;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] eb, input logic eo,
                                input int lat, input int busy_cnt, input int hold_bad);
        check({tag, " latency"}, 32'(lat), 32'd28);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd27);
        check({tag, " hold_during_conv"}, 32'(hold_bad), 32'd0);
        check({tag, " bcd"}, bus.bcd, eb);
        check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
        check({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
        prev_bcd = eb;
        prev_ovf = eo;
    endtask

    task automatic run_vec(input string tag, input logic [26:0] v, input logic [31:0] eb, input logic eo);
        int lat, bc, hb;
        start_conv(v);
        wait_done(0, '0, lat, bc, hb);
        check_result(tag, eb, eo, lat, bc, hb);
        @(negedge CLOCK_50);
        check({tag, " done_single_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat, bc, hb, seen;
        logic [31:0] mb;
        logic        mo;
        logic [26:0] rv;

        vecs[0] = '{27'd0,         32'h00000000, 1'b0};
        vecs[1] = '{27'd12345678,  32'h12345678, 1'b0};
        vecs[2] = '{27'd99999999,  32'h99999999, 1'b0};
        vecs[3] = '{27'd100000000, 32'h00000000, 1'b1};
        vecs[4] = '{27'd134217727, 32'h34217727, 1'b1};
        vecs[5] = '{27'd1,         32'h00000001, 1'b0};
        vecs[6] = '{27'd9,         32'h00000009, 1'b0};
        vecs[7] = '{27'd10,        32'h00000010, 1'b0};
        vecs[8] = '{27'd59,        32'h00000059, 1'b0};
        vecs[9] = '{27'd100000005, 32'h00000005, 1'b1};

        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset bcd", bus.bcd, 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        end

        for (int i = 0; i < 30; i++) begin
            rv = 27'($urandom_range(0, 134217727));
            model(32'(rv), mb, mo);
            run_vec($sformatf("rand%0d", i), rv, mb, mo);
        end

        // start during conversion is ignored and not queued
        start_conv(27'd42);
        wait_done(5, 27'd7, lat, bc, hb);
        check_result("ignore_start", 32'h00000042, 1'b0, lat, bc, hb);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (bus.done) seen++;
        end
        check("ignore_start no_extra_done", 32'(seen), 32'd0);

        // back-to-back: second start in the DONE cycle
        start_conv(27'd5);
        wait_done(0, '0, lat, bc, hb);
        check_result("b2b first", 32'h00000005, 1'b0, lat, bc, hb);
        start_conv(27'd9);
        check("b2b busy_after_done", 32'(bus.busy), 32'd1);
        wait_done(0, '0, lat, bc, hb);
        check_result("b2b second", 32'h00000009, 1'b0, lat, bc, hb);
        @(negedge CLOCK_50);

        // reset mid-conversion discards the result
        run_vec("pre_reset", 27'd42, 32'h00000042, 1'b0);
        start_conv(27'd999);
        repeat (9) @(negedge CLOCK_50);
        RESET = 1'b1;
        @(negedge CLOCK_50);
        RESET = 1'b0;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset bcd", bus.bcd, 32'd0);
        check("midreset ovf", 32'(bus.ovf), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (bus.done || bus.busy) seen++;
        end
        check("midreset stays_idle", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
